mmio_host_bridge: RTL and testbench
===================================

MMIO_HOST_BRIDGE -- requirements
Module: mmio_host_bridge

Interface
REQ-001 SHALL have parameters: HOST_DW 16, host data width; ADDR_W 16, memory address width; ARG_W 16, argument width; BUF_W 256, MMVR width; BUF_W a multiple of HOST_DW, NW = BUF_W/HOST_DW ≤ 16.
REQ-002 SHALL have ports:
- clk in 1, clock; rst_n in 1, reset (asynchronous, active-low).
- host_wr_en in 1, host register write strobe.
- host_rd_en in 1, host register read strobe.
- host_addr in 8, register address.
- host_wdata in HOST_DW, write data.
- host_rdata out HOST_DW, read data.
- host_rvalid out 1, read data valid.
- cmd_out out HOST_DW, command to control unit.
- addr_out out ADDR_W, memory address to control unit.
- arg_out out ARG_W, argument to control unit.
- mmvr_out out BUF_W, write vector to control unit.
- doorbell_pulse out 1, command trigger.
- status_in in HOST_DW, control unit status.
- mem_rdata in BUF_W, read-back vector.
- mem_rdata_valid in 1, read-back strobe.

Function
REQ-003 SHALL use register map: 0x00 CMD rw; 0x01 ADDR rw; 0x02 ARG rw; 0x03 STATUS r/w1c; 0x04 DOORBELL wo; 0x10+i MMVR word i, i < NW, rw, word 0 = bits [HOST_DW-1:0].
- Writes to unmapped addresses SHALL be ignored.
- Reads from unmapped addresses SHALL return 0.
REQ-004 SHALL drive cmd_out, addr_out, arg_out and mmvr_out directly from the CMD, ADDR, ARG and MMVR registers.
- Narrower fields SHALL take the LSBs of host_wdata.
REQ-005 Register reads SHALL have 1-cycle latency: host_rdata and host_rvalid are registered and valid the cycle after host_rd_en; host_rvalid is low otherwise.
REQ-006 STATUS read value SHALL be: [1:0] = status_in[1:0]; [2] = bridge_busy (FSM ≠ B_IDLE); [3] = err_sticky; [4] = rdata_ready; other bits 0.
REQ-007 A STATUS write with host_wdata[3]=1 SHALL clear err_sticky, and with host_wdata[4]=1 SHALL clear rdata_ready; other bits are ignored.
REQ-008 FSM states SHALL be B_IDLE, B_RING, B_SETTLE, B_WAIT.
REQ-009 In B_IDLE, a DOORBELL write SHALL:
- when status_in is `STATUS_IDLE or `STATUS_HALTED: go to B_RING and latch is_read = (CMD == `CMD_READ_MEM).
- otherwise: set err_sticky and stay in B_IDLE.
REQ-010 B_RING SHALL assert doorbell_pulse for exactly 1 cycle, then go to B_SETTLE.
REQ-011 B_SETTLE SHALL last 1 cycle, then go to B_WAIT.
REQ-012 B_WAIT SHALL return to B_IDLE when status_in is `STATUS_IDLE or `STATUS_HALTED.
REQ-013 When is_read is set, mem_rdata_valid in B_SETTLE or B_WAIT SHALL:
- copy mem_rdata into MMVR;
- set rdata_ready in the same cycle.
- mem_rdata_valid is ignored in all other cases.
REQ-014 While the FSM ≠ B_IDLE, host writes to CMD, ADDR, ARG, MMVR or DOORBELL SHALL be dropped and SHALL set err_sticky.
- STATUS writes and all reads SHALL remain serviced.
REQ-015 If a host write to MMVR word i and a read-back capture occur in the same cycle, the capture SHALL take priority.
REQ-016 Simultaneous host_wr_en and host_rd_en SHALL both be serviced.
- The read SHALL return the pre-write value.
REQ-017 doorbell_pulse SHALL never be asserted for 2 consecutive cycles; at least 3 cycles SHALL separate successive pulses.

Reset
REQ-018 On rst_n low, asynchronously: all registers 0; FSM = B_IDLE; doorbell_pulse, host_rvalid, host_rdata, err_sticky, rdata_ready, is_read all 0.
REQ-019 Reset asserted mid-command SHALL abort the FSM to B_IDLE with no further pulse.
- After reset release, bridge_busy SHALL read 0.

Verification
REQ-020 Write CMD=`CMD_WRITE_MEM, ADDR=0x0040, MMVR words 0..15 = 0x1000+i, DOORBELL, status_in idle -> exactly one doorbell_pulse 1 cycle after the DOORBELL write; mmvr_out[15:0]=0x1000, mmvr_out[255:240]=0x100F; STATUS[2] returns to 0.
REQ-021 CMD=`CMD_READ_MEM, DOORBELL; status_in BUSY 2 cycles; mem_rdata_valid with mem_rdata word 3 = 0xBEEF -> reading 0x13 returns 0xBEEF; STATUS[4]=1; write STATUS 0x10 -> STATUS[4]=0.
REQ-022 DOORBELL written while status_in = `STATUS_BUSY -> no pulse; STATUS[3]=1; write STATUS 0x08 -> STATUS[3]=0.
REQ-023 Write ADDR=0x1234 while bridge_busy -> addr_out unchanged; err_sticky=1. Read 0x01 -> old value, host_rvalid exactly 1 cycle.
REQ-024 Assert rst_n low during B_WAIT -> all outputs 0 immediately; no pulse after release.
REQ-025 CMD=`CMD_RUN with ARG=0x0005, status_in goes BUSY then `STATUS_HALTED -> FSM returns to B_IDLE; a second DOORBELL is accepted and pulses once.

Source files
------------

// File: rtl/mmio_host_bridge.sv
// mmio_host_bridge: host register file and doorbell sequencer in front of a memory control unit.
`ifndef STATUS_IDLE
`define STATUS_IDLE 0
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 1
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 2
`endif
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 1
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 2
`endif
`ifndef CMD_RUN
`define CMD_RUN 3
`endif
module mmio_host_bridge #(
   parameter int HOST_DW = 16,
   parameter int ADDR_W  = 16,
   parameter int ARG_W   = 16,
   parameter int BUF_W   = 256
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               host_wr_en,
   input  logic               host_rd_en,
   input  logic [7:0]         host_addr,
   input  logic [HOST_DW-1:0] host_wdata,
   output logic [HOST_DW-1:0] host_rdata,
   output logic               host_rvalid,
   output logic [HOST_DW-1:0] cmd_out,
   output logic [ADDR_W-1:0]  addr_out,
   output logic [ARG_W-1:0]   arg_out,
   output logic [BUF_W-1:0]   mmvr_out,
   output logic               doorbell_pulse,
   input  logic [HOST_DW-1:0] status_in,
   input  logic [BUF_W-1:0]   mem_rdata,
   input  logic               mem_rdata_valid
);
   localparam int NW = BUF_W / HOST_DW;
   typedef enum logic [1:0] {B_IDLE, B_RING, B_SETTLE, B_WAIT} state_e;
   state_e state_q, state_d;
   logic [HOST_DW-1:0] cmd_q, cmd_d, rdata_q, rdata_d, rd_val;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ARG_W-1:0] arg_q, arg_d;
   logic [NW-1:0][HOST_DW-1:0] mmvr_q, mmvr_d;
   logic err_q, err_d, rdy_q, rdy_d, isrd_q, isrd_d, rvalid_q;
   logic idle, st_ok, mm_hit, w_cmd, w_addr, w_arg, w_stat, w_db, w_mm, w_prot, capture;
   logic [3:0] widx;
   assign widx    = host_addr[3:0];
   assign idle    = state_q == B_IDLE;
   assign st_ok   = status_in == HOST_DW'(`STATUS_IDLE) || status_in == HOST_DW'(`STATUS_HALTED);
   assign mm_hit  = host_addr[7:4] == 4'h1 && 32'(widx) < NW;
   assign w_cmd   = host_wr_en && host_addr == 8'h00;
   assign w_addr  = host_wr_en && host_addr == 8'h01;
   assign w_arg   = host_wr_en && host_addr == 8'h02;
   assign w_stat  = host_wr_en && host_addr == 8'h03;
   assign w_db    = host_wr_en && host_addr == 8'h04;
   assign w_mm    = host_wr_en && mm_hit;
   assign w_prot  = w_cmd | w_addr | w_arg | w_db | w_mm;
   // Read-back is only accepted once the doorbell has been rung for a read command.
   assign capture = isrd_q && mem_rdata_valid && (state_q == B_SETTLE || state_q == B_WAIT);
   always_comb begin
      rd_val = '0;
      if (host_addr == 8'h00) rd_val = cmd_q;
      if (host_addr == 8'h01) rd_val = HOST_DW'(addr_q);
      if (host_addr == 8'h02) rd_val = HOST_DW'(arg_q);
      if (host_addr == 8'h03) rd_val = HOST_DW'({rdy_q, err_q, !idle, status_in[1:0]});
      if (mm_hit) rd_val = mmvr_q[widx];
   end
   always_comb begin
      state_d = state_q;
      cmd_d   = cmd_q;
      addr_d  = addr_q;
      arg_d   = arg_q;
      mmvr_d  = mmvr_q;
      err_d   = err_q;
      rdy_d   = rdy_q;
      isrd_d  = isrd_q;
      rdata_d = host_rd_en ? rd_val : '0;
      unique case (state_q)
         B_IDLE:   if (w_db && st_ok) begin
                      state_d = B_RING;
                      isrd_d  = cmd_q == HOST_DW'(`CMD_READ_MEM);
                   end
         B_RING:   state_d = B_SETTLE;
         B_SETTLE: state_d = B_WAIT;
         B_WAIT:   if (st_ok) state_d = B_IDLE;
      endcase
      if (idle) begin
         if (w_cmd) cmd_d = host_wdata;
         if (w_addr) addr_d = ADDR_W'(host_wdata);
         if (w_arg) arg_d = ARG_W'(host_wdata);
         if (w_mm) mmvr_d[widx] = host_wdata;
      end
      if (capture) mmvr_d = mem_rdata;
      // Clears come first so a simultaneous error or capture event is never lost.
      if (w_stat && host_wdata[3]) err_d = 1'b0;
      if (w_stat && host_wdata[4]) rdy_d = 1'b0;
      if ((!idle && w_prot) || (idle && w_db && !st_ok)) err_d = 1'b1;
      if (capture) rdy_d = 1'b1;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= B_IDLE;
         cmd_q    <= '0;
         addr_q   <= '0;
         arg_q    <= '0;
         mmvr_q   <= '0;
         err_q    <= 1'b0;
         rdy_q    <= 1'b0;
         isrd_q   <= 1'b0;
         rdata_q  <= '0;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         cmd_q    <= cmd_d;
         addr_q   <= addr_d;
         arg_q    <= arg_d;
         mmvr_q   <= mmvr_d;
         err_q    <= err_d;
         rdy_q    <= rdy_d;
         isrd_q   <= isrd_d;
         rdata_q  <= rdata_d;
         rvalid_q <= host_rd_en;
      end
   end
   assign cmd_out        = cmd_q;
   assign addr_out       = addr_q;
   assign arg_out        = arg_q;
   assign mmvr_out       = mmvr_q;
   assign doorbell_pulse = state_q == B_RING;
   assign host_rdata     = rdata_q;
   assign host_rvalid    = rvalid_q;
endmodule

// File: tb/tb_mmio_host_bridge.sv
// tb_mmio_host_bridge: randomized and directed scoreboard bench for mmio_host_bridge.
`ifndef STATUS_IDLE
`define STATUS_IDLE 0
`endif
`ifndef STATUS_BUSY
`define STATUS_BUSY 1
`endif
`ifndef STATUS_HALTED
`define STATUS_HALTED 2
`endif
`ifndef CMD_WRITE_MEM
`define CMD_WRITE_MEM 1
`endif
`ifndef CMD_READ_MEM
`define CMD_READ_MEM 2
`endif
`ifndef CMD_RUN
`define CMD_RUN 3
`endif
module tb_mmio_host_bridge;
   logic clk = 1'b0, rst_n = 1'b0;
   logic host_wr_en = 1'b0, host_rd_en = 1'b0, mem_rdata_valid = 1'b0, doorbell_pulse, host_rvalid;
   logic [7:0] host_addr = '0;
   logic [15:0] host_wdata = '0, host_rdata, cmd_out, addr_out, arg_out, status_in = '0;
   logic [255:0] mmvr_out, mem_rdata = '0;
   always #5 clk = ~clk;
   mmio_host_bridge dut (
      .clk(clk), .rst_n(rst_n), .host_wr_en(host_wr_en), .host_rd_en(host_rd_en),
      .host_addr(host_addr), .host_wdata(host_wdata), .host_rdata(host_rdata),
      .host_rvalid(host_rvalid), .cmd_out(cmd_out), .addr_out(addr_out), .arg_out(arg_out),
      .mmvr_out(mmvr_out), .doorbell_pulse(doorbell_pulse), .status_in(status_in),
      .mem_rdata(mem_rdata), .mem_rdata_valid(mem_rdata_valid)
   );
   typedef struct {
      logic rv; logic [15:0] rd; logic pulse;
      logic [15:0] cmd, addr, arg; logic [255:0] mm;
   } exp_t;
   exp_t q[$];
   int n_chk = 0, n_fail = 0, pulse_cnt = 0, cyc = 0, last_pulse = -100;
   logic [15:0] m_cmd, m_addr, m_arg;
   logic [15:0] m_mm[16];
   bit m_err, m_rdy, m_busy, m_isrd;
   int m_age;
   logic [15:0] cur_st = 16'd`STATUS_IDLE;
   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask
   function automatic logic [15:0] model_read(input logic [7:0] a);
      if (a == 8'h00) return m_cmd;
      if (a == 8'h01) return m_addr;
      if (a == 8'h02) return m_arg;
      if (a == 8'h03) return {11'd0, m_rdy, m_err, m_busy, status_in[1:0]};
      if (a >= 8'h10 && a <= 8'h1F) return m_mm[a - 8'h10];
      return 16'h0;
   endfunction
   // Abstract model: after an accepted doorbell the bridge is busy for at least
   // two cycles (pulse, settle) and then until the control unit reports idle/halted.
   task automatic model(output exp_t e);
      bit stok, db, prot, is_mm;
      e.rv = 0;
      e.rd = '0;
      if (!rst_n) begin
         m_cmd = '0; m_addr = '0; m_arg = '0;
         foreach (m_mm[i]) m_mm[i] = '0;
         m_err = 0; m_rdy = 0; m_busy = 0; m_isrd = 0; m_age = 0;
      end else begin
         stok = status_in == 16'd`STATUS_IDLE || status_in == 16'd`STATUS_HALTED;
         if (host_rd_en) begin e.rv = 1; e.rd = model_read(host_addr); end
         is_mm = host_addr >= 8'h10 && host_addr <= 8'h1F;
         db = host_wr_en && host_addr == 8'h04;
         prot = host_wr_en && (host_addr <= 8'h02 || host_addr == 8'h04 || is_mm);
         if (host_wr_en && host_addr == 8'h03) begin
            if (host_wdata[3]) m_err = 0;
            if (host_wdata[4]) m_rdy = 0;
         end
         if (m_busy && prot) m_err = 1;
         if (!m_busy && host_wr_en) begin
            if (host_addr == 8'h00) m_cmd = host_wdata;
            if (host_addr == 8'h01) m_addr = host_wdata;
            if (host_addr == 8'h02) m_arg = host_wdata;
            if (is_mm) m_mm[host_addr - 8'h10] = host_wdata;
         end
         if (m_busy && m_age >= 1 && m_isrd && mem_rdata_valid) begin
            for (int i = 0; i < 16; i++) m_mm[i] = mem_rdata[16*i +: 16];
            m_rdy = 1;
         end
         if (m_busy) begin
            if (m_age >= 2 && stok) m_busy = 0;
            else if (m_age < 3) m_age++;
         end else if (db && stok) begin
            m_busy = 1; m_age = 0; m_isrd = m_cmd == 16'd`CMD_READ_MEM;
         end else if (db) m_err = 1;
      end
      e.pulse = m_busy && m_age == 0;
      e.cmd = m_cmd; e.addr = m_addr; e.arg = m_arg;
      for (int i = 0; i < 16; i++) e.mm[16*i +: 16] = m_mm[i];
   endtask
   task automatic step(input bit rn, input bit wr, input bit rd, input logic [7:0] a,
                       input logic [15:0] wd, input bit mv, input logic [255:0] md);
      exp_t e;
      @(negedge clk);
      rst_n = rn; host_wr_en = wr; host_rd_en = rd; host_addr = a; host_wdata = wd;
      status_in = cur_st; mem_rdata_valid = mv; mem_rdata = md;
      model(e);
      q.push_back(e);
   endtask
   task automatic wr(input logic [7:0] a, input logic [15:0] d); step(1, 1, 0, a, d, 0, '0); endtask
   task automatic rd(input logic [7:0] a); step(1, 0, 1, a, '0, 0, '0); endtask
   task automatic idle(input int n); for (int i = 0; i < n; i++) step(1, 0, 0, '0, '0, 0, '0); endtask
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         if (doorbell_pulse) begin
            pulse_cnt++;
            chk("pulse_spacing_ok", 256'(cyc - last_pulse >= 4), 256'(1));
            last_pulse = cyc;
         end
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("rvalid", 256'(host_rvalid), 256'(e.rv));
            if (host_rvalid || e.rv) chk("rdata", 256'(host_rdata), 256'(e.rd));
            chk("doorbell_pulse", 256'(doorbell_pulse), 256'(e.pulse));
            chk("cmd_out", 256'(cmd_out), 256'(e.cmd));
            chk("addr_out", 256'(addr_out), 256'(e.addr));
            chk("arg_out", 256'(arg_out), 256'(e.arg));
            chk("mmvr_out", mmvr_out, e.mm);
         end
      end
   end
   initial begin
      int p0;
      logic [255:0] md;
      logic [7:0] addrs[12] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h10, 8'h13, 8'h1F, 8'h20, 8'hFF, 8'h04};
      for (int i = 0; i < 3; i++) step(0, 0, 0, '0, '0, 0, '0);
      rd(8'h03);
      rd(8'h00);
      // write-memory command with a full MMVR fill
      wr(8'h00, 16'd`CMD_WRITE_MEM);
      wr(8'h01, 16'h0040);
      for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i), 16'h1000 + 16'(i));
      p0 = pulse_cnt;
      wr(8'h04, 16'h0);
      idle(4);
      rd(8'h03);
      idle(1);
      chk("req020_pulse_count", 256'(pulse_cnt - p0), 256'(1));
      chk("req020_word0", 256'(mmvr_out[15:0]), 256'(16'h1000));
      chk("req020_word15", 256'(mmvr_out[255:240]), 256'(16'h100F));
      // read-memory command with capture
      wr(8'h00, 16'd`CMD_READ_MEM);
      wr(8'h04, 16'h0);
      cur_st = 16'd`STATUS_BUSY;
      idle(2);
      md = {16{16'h5A5A}};
      md[63:48] = 16'hBEEF;
      step(1, 0, 1, 8'h03, '0, 1, md);
      cur_st = 16'd`STATUS_IDLE;
      idle(3);
      rd(8'h13); rd(8'h03);
      wr(8'h03, 16'h0010);
      rd(8'h03);
      // doorbell refused while the control unit is busy
      cur_st = 16'd`STATUS_BUSY;
      p0 = pulse_cnt;
      wr(8'h04, 16'h0);
      idle(2);
      rd(8'h03);
      wr(8'h03, 16'h0008);
      rd(8'h03);
      idle(1);
      chk("req022_no_pulse", 256'(pulse_cnt - p0), 256'(0));
      // protected write while busy, with a simultaneous read
      cur_st = 16'd`STATUS_IDLE;
      wr(8'h00, 16'd`CMD_WRITE_MEM);
      wr(8'h04, 16'h0);
      cur_st = 16'd`STATUS_BUSY;
      idle(2);
      step(1, 1, 1, 8'h01, 16'h1234, 0, '0);
      rd(8'h01); rd(8'h03);
      idle(1);
      // asynchronous reset in the wait state
      wr(8'h00, 16'd`CMD_RUN);
      idle(1);
      step(0, 0, 0, '0, '0, 0, '0);
      #1;
      chk("req024_pulse_async", 256'(doorbell_pulse), 256'(0));
      chk("req024_mmvr_async", mmvr_out, 256'(0));
      chk("req024_addr_async", 256'(addr_out), 256'(0));
      step(0, 0, 0, '0, '0, 0, '0);
      cur_st = 16'd`STATUS_IDLE;
      p0 = pulse_cnt;
      idle(4);
      rd(8'h03);
      idle(1);
      chk("req024_no_pulse", 256'(pulse_cnt - p0), 256'(0));
      // run command ending halted, then a second accepted doorbell
      wr(8'h00, 16'd`CMD_RUN);
      wr(8'h02, 16'h0005);
      p0 = pulse_cnt;
      wr(8'h04, 16'h0);
      cur_st = 16'd`STATUS_BUSY;
      idle(3);
      cur_st = 16'd`STATUS_HALTED;
      idle(2);
      rd(8'h03);
      wr(8'h04, 16'h0);
      idle(5);
      chk("req025_pulse_count", 256'(pulse_cnt - p0), 256'(2));
      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 7) == 0) cur_st = 16'($urandom_range(0, 3));
         md = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
         step($urandom_range(0, 299) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
              addrs[$urandom_range(0, 11)], 16'($urandom), $urandom_range(0, 5) == 0, md);
      end
      idle(3);
      @(posedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
